// File: rtl/tamarac_datapath.sv
// tamarac_datapath
// Bus-centred datapath and main memory of the Tamarac processor. Registers
// PC, MAR, ACC, IR, ARG and BUF share one 16-bit internal bus. The
// microprogrammed controller selects the bus source with read strobes and
// the destinations with write strobes. State changes only on a clock edge
// where step=1.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   step                  write enable for every register and memory write
//   sw[15:0]              front-panel switch value (bus source rsw)
//   rsw rpc racc rir rmem rbuf   bus read strobes (source drives bus)
//   wpc wmar wacc wir warg wbuf wmem   bus write strobes (destination loads)
//   alucntl[1:0]          ALU function: 00 NUL, 01 INC, 10 ADD, 11 SUB
//   acc[15:0]             accumulator
//   opc[2:0]              opcode field ir[15:13]
//   pc[AW-1:0]            program counter
//   bus[15:0]             current internal bus value
//   bus_err               sticky flag: more than one read strobe on a step
module tamarac_datapath #(
  parameter int AW = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          step,
  input  logic [15:0]   sw,
  input  logic          rsw,
  input  logic          rpc,
  input  logic          racc,
  input  logic          rir,
  input  logic          rmem,
  input  logic          rbuf,
  input  logic          wpc,
  input  logic          wmar,
  input  logic          wacc,
  input  logic          wir,
  input  logic          warg,
  input  logic          wbuf,
  input  logic          wmem,
  input  logic [1:0]    alucntl,
  output logic [15:0]   acc,
  output logic [2:0]    opc,
  output logic [AW-1:0] pc,
  output logic [15:0]   bus,
  output logic          bus_err
);

  localparam int DATA_W = 16;

  localparam logic [1:0] ALU_NUL = 2'b00;
  localparam logic [1:0] ALU_INC = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  logic [AW-1:0]     mar;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] arg;
  logic [DATA_W-1:0] buf_r;
  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] alu_out;
  logic              multi_rd;
  logic              wr_en;

  // ALU result wraps modulo 2^16; no carry or flags leave the datapath.
  function automatic logic [DATA_W-1:0] alu_f(input logic [1:0]        f,
                                              input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (f)
      ALU_NUL: r = b;
      ALU_INC: r = b + 16'd1;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      default: r = b;
    endcase
    return r;
  endfunction

  // Asynchronous memory read so rmem is usable in the step right after wmar.
  assign mem_rd = mem[mar];

  // Several simultaneous sources resolve as a wired-OR, matching the
  // open-bus behaviour the front panel shows.
  always_comb begin
    bus = '0;
    if (rsw)  bus = bus | sw;
    if (rpc)  bus = bus | DATA_W'(pc);
    if (racc) bus = bus | acc;
    if (rir)  bus = bus | DATA_W'(ir[AW-1:0]);
    if (rmem) bus = bus | mem_rd;
    if (rbuf) bus = bus | buf_r;
  end

  assign multi_rd = ($countones({rsw, rpc, racc, rir, rmem, rbuf}) > 1);
  assign alu_out  = alu_f(alucntl, arg, bus);
  assign opc      = ir[15:13];

  // Reset wins over a coincident step, so a write strobe during reset is lost.
  assign wr_en = step && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc      <= '0;
      mar     <= '0;
      acc     <= '0;
      ir      <= '0;
      arg     <= '0;
      buf_r   <= '0;
      bus_err <= 1'b0;
    end else if (step) begin
      if (wpc)      pc      <= bus[AW-1:0];
      if (wmar)     mar     <= bus[AW-1:0];
      if (wacc)     acc     <= bus;
      if (wir)      ir      <= bus;
      if (warg)     arg     <= bus;
      if (wbuf)     buf_r   <= alu_out;
      if (multi_rd) bus_err <= 1'b1;
    end
  end

  // Memory contents are never reset. Address is the pre-edge mar, so a
  // combined wmar+wmem step stores to the old address.
  always_ff @(posedge clock) begin
    if (wr_en && wmem) mem[mar] <= bus;
  end

endmodule

// File: tb/tb_tamarac_datapath.sv
module tb_tamarac_datapath;

  localparam int AW = 13;

  localparam logic [5:0] R_NONE = 6'b000000;
  localparam logic [5:0] R_SW   = 6'b100000;
  localparam logic [5:0] R_PC   = 6'b010000;
  localparam logic [5:0] R_ACC  = 6'b001000;
  localparam logic [5:0] R_IR   = 6'b000100;
  localparam logic [5:0] R_MEM  = 6'b000010;
  localparam logic [5:0] R_BUF  = 6'b000001;

  localparam logic [6:0] W_NONE = 7'b0000000;
  localparam logic [6:0] W_PC   = 7'b1000000;
  localparam logic [6:0] W_MAR  = 7'b0100000;
  localparam logic [6:0] W_ACC  = 7'b0010000;
  localparam logic [6:0] W_IR   = 7'b0001000;
  localparam logic [6:0] W_ARG  = 7'b0000100;
  localparam logic [6:0] W_BUF  = 7'b0000010;
  localparam logic [6:0] W_MEM  = 7'b0000001;

  localparam logic [1:0] F_NUL = 2'b00;
  localparam logic [1:0] F_INC = 2'b01;
  localparam logic [1:0] F_ADD = 2'b10;
  localparam logic [1:0] F_SUB = 2'b11;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          step = 1'b0;
  logic [15:0]   sw = '0;
  logic [5:0]    rd = '0;
  logic [6:0]    wr = '0;
  logic [1:0]    f_sel = '0;
  logic [15:0]   acc;
  logic [2:0]    opc;
  logic [AW-1:0] pc;
  logic [15:0]   bus;
  logic          bus_err;

  int total = 0;
  int bad = 0;

  // Reference model state
  int m_pc, m_mar, m_acc, m_ir, m_arg, m_buf;
  bit m_err;
  int m_mem [int];

  always #5 clock = ~clock;

  tamarac_datapath #(.AW(AW)) dut (
    .clock(clock), .reset(reset), .step(step), .sw(sw),
    .rsw(rd[5]), .rpc(rd[4]), .racc(rd[3]), .rir(rd[2]), .rmem(rd[1]), .rbuf(rd[0]),
    .wpc(wr[6]), .wmar(wr[5]), .wacc(wr[4]), .wir(wr[3]), .warg(wr[2]),
    .wbuf(wr[1]), .wmem(wr[0]),
    .alucntl(f_sel), .acc(acc), .opc(opc), .pc(pc), .bus(bus), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_bus(input logic [5:0] r, input logic [15:0] s);
    int v;
    v = 0;
    if (r[5]) v = v | int'(s);
    if (r[4]) v = v | m_pc;
    if (r[3]) v = v | m_acc;
    if (r[2]) v = v | (m_ir % (1 << AW));
    if (r[1]) begin
      if (m_mem.exists(m_mar)) v = v | m_mem[m_mar];
      else return 16'hxxxx;
    end
    if (r[0]) v = v | m_buf;
    return 16'(v);
  endfunction

  function automatic int model_alu(input logic [1:0] f, input int b);
    int r;
    case (f)
      F_INC:   r = b + 1;
      F_ADD:   r = m_arg + b;
      F_SUB:   r = m_arg - b + 65536;
      default: r = b;
    endcase
    return r % 65536;
  endfunction

  task automatic model_reset();
    m_pc = 0; m_mar = 0; m_acc = 0; m_ir = 0; m_arg = 0; m_buf = 0; m_err = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".acc"}, 32'(acc), 32'(m_acc));
    chk({tag, ".pc"}, 32'(pc), 32'(m_pc));
    chk({tag, ".opc"}, 32'(opc), 32'(m_ir / 8192));
    chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
  endtask

  // One step: drive strobes, check the bus before the edge, clock, update
  // the model and compare all visible state.
  task automatic apply(input logic [5:0] r, input logic [6:0] w,
                       input logic [1:0] f, input logic [15:0] s, input string tag);
    logic [15:0] eb;
    int addr, a;
    eb = model_bus(r, s);
    rd = r; wr = w; f_sel = f; sw = s; step = 1'b1;
    #1;
    chk({tag, ".bus"}, 32'(bus), 32'(eb));
    @(posedge clock);
    #1;
    step = 1'b0; rd = R_NONE; wr = W_NONE;
    addr = m_mar;
    a = model_alu(f, int'(eb));
    if ($countones(r) > 1) m_err = 1;
    if (w[6]) m_pc  = int'(eb) % (1 << AW);
    if (w[5]) m_mar = int'(eb) % (1 << AW);
    if (w[4]) m_acc = int'(eb);
    if (w[3]) m_ir  = int'(eb);
    if (w[2]) m_arg = int'(eb);
    if (w[1]) m_buf = a;
    if (w[0]) m_mem[addr] = int'(eb);
    check_outputs(tag);
  endtask

  task automatic peek(input logic [5:0] r, input logic [15:0] exp, input string tag);
    rd = r;
    #1;
    chk(tag, 32'(bus), 32'(exp));
    rd = R_NONE;
    #1;
  endtask

  initial begin
    logic [5:0] r;
    logic [6:0] w;
    logic [15:0] s;
    int k;

    // Reset, no strobes
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    check_outputs("reset");
    peek(R_NONE, 16'h0000, "reset.bus_idle");

    // PC load and hold with step=0
    apply(R_SW, W_PC, F_NUL, 16'h0040, "ld_pc");
    chk("ld_pc.pc_const", 32'(pc), 32'h040);
    rd = R_SW; wr = W_PC; sw = 16'h1234; step = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    rd = R_NONE; wr = W_NONE;
    chk("hold.pc", 32'(pc), 32'h040);

    // Store acc to mem[pc]
    apply(R_SW, W_PC, F_NUL, 16'h0010, "st_pc");
    apply(R_PC, W_MAR, F_NUL, 16'h0000, "st_mar");
    apply(R_SW, W_ACC, F_NUL, 16'h1234, "st_acc");
    apply(R_ACC, W_MEM, F_NUL, 16'h0000, "st_mem");
    peek(R_MEM, 16'h1234, "st.readback");

    // ADD: mem[5]=7, acc=3
    apply(R_SW, W_MAR, F_NUL, 16'h0005, "add_mar");
    apply(R_SW, W_MEM, F_NUL, 16'h0007, "add_mem");
    apply(R_SW, W_ACC, F_NUL, 16'h0003, "add_acc");
    apply(R_ACC, W_ARG, F_NUL, 16'h0000, "add_arg");
    apply(R_SW, W_IR, F_NUL, 16'h0005, "add_ir");
    apply(R_IR, W_MAR, F_NUL, 16'h0000, "add_irmar");
    apply(R_MEM, W_BUF, F_ADD, 16'h0000, "add_alu");
    apply(R_BUF, W_ACC, F_NUL, 16'h0000, "add_res");
    chk("add.acc_const", 32'(acc), 32'h000A);

    // SUB wrap: 0 - 1
    apply(R_SW, W_MEM, F_NUL, 16'h0001, "sub_mem");
    apply(R_SW, W_ACC, F_NUL, 16'h0000, "sub_acc");
    apply(R_ACC, W_ARG, F_NUL, 16'h0000, "sub_arg");
    apply(R_MEM, W_BUF, F_SUB, 16'h0000, "sub_alu");
    apply(R_BUF, W_ACC, F_NUL, 16'h0000, "sub_res");
    chk("sub.acc_const", 32'(acc), 32'hFFFF);

    // INC wrap of pc
    apply(R_SW, W_PC, F_NUL, 16'h1FFF, "inc_pc");
    apply(R_PC, W_BUF, F_INC, 16'h0000, "inc_alu");
    peek(R_BUF, 16'h2000, "inc.buf");
    apply(R_BUF, W_PC, F_NUL, 16'h0000, "inc_wrap");
    chk("inc.pc_const", 32'(pc), 32'h0);

    // Fetch
    apply(R_SW, W_MAR, F_NUL, 16'h0000, "fe_mar");
    apply(R_SW, W_MEM, F_NUL, 16'hA005, "fe_mem");
    apply(R_MEM, W_IR, F_NUL, 16'h0000, "fe_ir");
    chk("fe.opc_const", 32'(opc), 32'h5);
    peek(R_IR, 16'h0005, "fe.rir");

    // wmar+wmem together: store goes to pre-edge mar (0)
    apply(R_SW, W_MAR | W_MEM | W_ACC | W_ARG, F_NUL, 16'h0BEE, "mm_both");
    apply(R_SW, W_MAR, F_NUL, 16'h0000, "mm_back");
    peek(R_MEM, 16'h0BEE, "mm.old_addr");
    peek(R_MEM, model_bus(R_MEM, 16'h0000), "mm.model");
    apply(R_SW, W_MAR, F_NUL, 16'h0BEE, "mm_new");
    peek(R_MEM, model_bus(R_MEM, 16'h0000), "mm.new_addr_model");
    apply(R_SW, W_MAR, F_NUL, 16'h0000, "mm_restore");

    // Randomized single-source steps
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 6);
      r = (k == 6) ? R_NONE : 6'(6'b100000 >> k);
      if (r == R_MEM && !m_mem.exists(m_mar)) r = R_SW;
      w = 7'(($urandom & $urandom) & 32'h7F);
      s = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      apply(r, w, 2'($urandom_range(0, 3)), s, "rnd");
    end

    // Bus conflict and sticky error
    apply(R_SW, W_PC, F_NUL, 16'h00F0, "cf_pc");
    apply(R_SW, W_ACC, F_NUL, 16'h000F, "cf_acc");
    apply(R_PC | R_ACC, W_NONE, F_NUL, 16'h0000, "cf_both");
    chk("cf.err_const", 32'(bus_err), 32'h1);
    peek(R_PC | R_ACC, 16'h00FF, "cf.bus_const");
    apply(R_SW, W_ACC, F_NUL, 16'h0055, "cf_after");
    chk("cf.sticky", 32'(bus_err), 32'h1);

    // Reset with step and strobes active; memory write must be discarded
    apply(R_SW, W_MAR, F_NUL, 16'h0000, "rs_mar");
    rd = R_SW; wr = 7'h7F; sw = 16'hFFFF; f_sel = F_INC; step = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; step = 1'b0; rd = R_NONE; wr = W_NONE;
    model_reset();
    check_outputs("rst2");
    peek(R_BUF, 16'h0000, "rst2.buf");
    peek(R_IR, 16'h0000, "rst2.ir");
    peek(R_MEM, model_bus(R_MEM, 16'h0000), "rst2.mem0");
    apply(R_SW, W_BUF, F_SUB, 16'h0000, "rst2_arg");
    peek(R_BUF, 16'h0000, "rst2.arg");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
